// File: rtl/inst_data_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data bus arbiter.
// State encodings, the watchdog counter width and the bus constants used by the core.
package inst_data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_IF_ACC  = 2'b01,
        ARB_MEM_ACC = 2'b10
    } arb_state_e;

    localparam int ARB_TIMEOUT_W = 8;
    typedef logic [ARB_TIMEOUT_W-1:0] arb_timeout_t;

    localparam logic [3:0] SEL_ALL      = 4'b1111;
    localparam logic       RST_ENABLE   = 1'b1;
    localparam logic       CHIP_ENABLE  = 1'b1;
    localparam logic       WRITE_ENABLE = 1'b1;

endpackage

// File: rtl/inst_data_bus_arbiter_watchdog.sv
// Bus watchdog: 8-bit counter cleared on grant, advanced on each un-acked access cycle.
// expire_o flags the last allowed access cycle.
module inst_data_bus_arbiter_watchdog
    import inst_data_bus_arbiter_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    arb_timeout_t cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Count starts at 0 in the first access cycle, so LIMIT-1 marks the LIMIT-th cycle.
    assign expire_o = (cnt_q == arb_timeout_t'(LIMIT - 1));

endmodule

// File: rtl/inst_data_bus_arbiter.sv
// Shares one single-port memory bus between the fetch and load/store ports.
// Fixed priority (data over fetch), registered bus outputs, watchdog abort of hung accesses.
module inst_data_bus_arbiter
    import inst_data_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_stall_o,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_stall_o,
    output logic              stallreq_o,
    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              bus_ack_i,
    output logic              timeout_o
);

    arb_state_e        state_q;
    logic              if_done_q, mem_done_q, timeout_q;
    logic              bus_ce_q, bus_we_q;
    logic [3:0]        bus_sel_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_data_q, if_data_q, mem_data_q;

    logic in_acc, turnaround, grant_mem, grant_if, expire;

    // The done cycle doubles as a bus turnaround: nothing is granted while a result is presented.
    assign turnaround = if_done_q | mem_done_q;
    assign in_acc     = (state_q != ARB_IDLE);
    assign grant_mem  = (state_q == ARB_IDLE) && !turnaround && mem_ce_i && !mem_done_q;
    assign grant_if   = (state_q == ARB_IDLE) && !turnaround && !grant_mem && if_ce_i && !if_done_q;

    inst_data_bus_arbiter_watchdog #(
        .LIMIT(TIMEOUT_CYC)
    ) u_arb_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (grant_mem | grant_if),
        .en_i     (in_acc & ~bus_ack_i),
        .expire_o (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q    <= ARB_IDLE;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            timeout_q  <= 1'b0;
            bus_ce_q   <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_sel_q  <= '0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            if_data_q  <= '0;
            mem_data_q <= '0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (grant_mem) begin
                        state_q    <= ARB_MEM_ACC;
                        bus_ce_q   <= CHIP_ENABLE;
                        bus_we_q   <= mem_we_i;
                        bus_sel_q  <= mem_sel_i;
                        bus_addr_q <= mem_addr_i;
                        bus_data_q <= mem_data_i;
                    end else if (grant_if) begin
                        state_q    <= ARB_IF_ACC;
                        bus_ce_q   <= CHIP_ENABLE;
                        bus_we_q   <= ~WRITE_ENABLE;
                        bus_sel_q  <= SEL_ALL;
                        bus_addr_q <= if_addr_i;
                        bus_data_q <= '0;
                    end
                end
                ARB_IF_ACC: begin
                    if (bus_ack_i || expire) begin
                        if_data_q <= bus_ack_i ? bus_data_i : '0;
                        if_done_q <= 1'b1;
                        timeout_q <= ~bus_ack_i;
                        bus_ce_q  <= 1'b0;
                        state_q   <= ARB_IDLE;
                    end
                end
                ARB_MEM_ACC: begin
                    if (bus_ack_i || expire) begin
                        // Stores never touch the load data register.
                        if (bus_we_q != WRITE_ENABLE) begin
                            mem_data_q <= bus_ack_i ? bus_data_i : '0;
                        end
                        mem_done_q <= 1'b1;
                        timeout_q  <= ~bus_ack_i;
                        bus_ce_q   <= 1'b0;
                        state_q    <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q  <= ARB_IDLE;
                    bus_ce_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_stall_o  = if_ce_i & ~if_done_q;
    assign mem_stall_o = mem_ce_i & ~mem_done_q;
    assign stallreq_o  = if_stall_o | mem_stall_o;

    assign bus_ce_o   = bus_ce_q;
    assign bus_we_o   = bus_we_q;
    assign bus_sel_o  = bus_sel_q;
    assign bus_addr_o = bus_addr_q;
    assign bus_data_o = bus_data_q;
    assign if_data_o  = if_data_q;
    assign mem_data_o = mem_data_q;
    assign timeout_o  = timeout_q;

endmodule
